// File: rtl/vc_pkg.sv
// Shared types and width helpers for the victim-cache tag store.
package vc_pkg;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_SCAN = 2'd1,
        FL_WB   = 2'd2
    } flush_state_e;

    function automatic int vc_idxw(input int n);
        return $clog2(n);
    endfunction

    function automatic int vc_cntw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vc_lru_ages.sv
// Per-way LRU ages kept as a permutation; age 0 is MRU, NUM_WAYS-1 is LRU.
module vc_lru_ages import vc_pkg::*; #(
    parameter  int NUM_WAYS = 4,
    localparam int IDXW     = vc_idxw(NUM_WAYS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            touch_en_i,
    input  logic [IDXW-1:0] touch_way_i,
    output logic [IDXW-1:0] lru_way_o
);

    logic [NUM_WAYS-1:0][IDXW-1:0] age_q, age_d;
    logic [IDXW-1:0]               old_age;

    assign old_age = age_q[touch_way_i];

    always_comb begin
        age_d = age_q;
        if (touch_en_i) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (IDXW'(i) == touch_way_i)  age_d[i] = '0;
                else if (age_q[i] < old_age)  age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        lru_way_o = '0;
        for (int i = 0; i < NUM_WAYS; i++)
            if (age_q[i] == IDXW'(NUM_WAYS - 1)) lru_way_o = IDXW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WAYS; i++) age_q[i] <= IDXW'(i);
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/vc_tag_store_lru.sv
// Fully associative tag store with LRU victim selection and a dirty-line flush walker.
module vc_tag_store_lru import vc_pkg::*; #(
    parameter  int TAG_WIDTH = 20,
    parameter  int NUM_WAYS  = 4,
    localparam int IDXW      = vc_idxw(NUM_WAYS),
    localparam int CNTW      = vc_cntw(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lookup_en,
    input  logic [TAG_WIDTH-1:0] lookup_tag,
    output logic                 hit_valid,
    output logic                 hit,
    output logic [IDXW-1:0]      hit_way,
    output logic                 hit_dirty,
    input  logic                 install_en,
    input  logic [TAG_WIDTH-1:0] install_tag,
    input  logic                 install_dirty,
    output logic [IDXW-1:0]      victim_way,
    output logic                 victim_valid,
    output logic [TAG_WIDTH-1:0] victim_tag,
    output logic                 victim_dirty,
    input  logic                 inv_en,
    input  logic [IDXW-1:0]      inv_way,
    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 flush_done,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic [IDXW-1:0]      wb_way,
    output logic [CNTW-1:0]      occupancy
);

    logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
    logic [NUM_WAYS-1:0]                valid_q, valid_d, dirty_q, dirty_d;
    flush_state_e                       state_q, state_d;
    logic [IDXW-1:0]                    ptr_q, ptr_d;
    logic                               hit_valid_q, hit_q, hit_dirty_q, flush_done_q, flush_done_d;
    logic [IDXW-1:0]                    hit_way_q;

    logic            look_hit, any_inv, retire;
    logic [IDXW-1:0] look_way, inv_idx, lru_way, touch_way;
    logic            do_lookup, do_install, do_inv, touch_en;

    assign flush_busy = (state_q != FL_IDLE);
    assign do_lookup  = lookup_en  & ~flush_busy;
    assign do_inv     = inv_en     & ~flush_busy;
    // An invalidate aimed at the install target wins; the install is dropped entirely.
    assign do_install = install_en & ~flush_busy & ~(do_inv && inv_way == victim_way);

    // Descending scans so the lowest matching / lowest invalid index wins.
    always_comb begin
        look_hit = 1'b0;
        look_way = '0;
        any_inv  = 1'b0;
        inv_idx  = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == lookup_tag) begin
                look_hit = 1'b1;
                look_way = IDXW'(i);
            end
            if (!valid_q[i]) begin
                any_inv = 1'b1;
                inv_idx = IDXW'(i);
            end
        end
    end

    assign victim_way   = any_inv ? inv_idx : lru_way;
    assign victim_valid = valid_q[victim_way];
    assign victim_tag   = tag_q[victim_way];
    assign victim_dirty = dirty_q[victim_way];

    assign touch_en  = do_install | (do_lookup & look_hit & ~install_en);
    assign touch_way = do_install ? victim_way : look_way;

    vc_lru_ages #(.NUM_WAYS(NUM_WAYS)) u_ages (
        .clk         (clk),
        .rst_n       (rst_n),
        .touch_en_i  (touch_en),
        .touch_way_i (touch_way),
        .lru_way_o   (lru_way)
    );

    assign retire = (state_q == FL_SCAN && !(valid_q[ptr_q] && dirty_q[ptr_q])) ||
                    (state_q == FL_WB && wb_ready);

    always_comb begin
        tag_d        = tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        state_d      = state_q;
        ptr_d        = ptr_q;
        flush_done_d = 1'b0;
        if (do_install) begin
            tag_d[victim_way]   = install_tag;
            valid_d[victim_way] = 1'b1;
            dirty_d[victim_way] = install_dirty;
        end
        if (do_inv) begin
            tag_d[inv_way]   = '0;
            valid_d[inv_way] = 1'b0;
            dirty_d[inv_way] = 1'b0;
        end
        if (state_q == FL_IDLE && flush_req) begin
            state_d = FL_SCAN;
            ptr_d   = '0;
        end else if (state_q == FL_SCAN && !retire) begin
            state_d = FL_WB;
        end
        if (retire) begin
            tag_d[ptr_q]   = '0;
            valid_d[ptr_q] = 1'b0;
            dirty_d[ptr_q] = 1'b0;
            if (ptr_q == IDXW'(NUM_WAYS - 1)) begin
                state_d      = FL_IDLE;
                ptr_d        = '0;
                flush_done_d = 1'b1;
            end else begin
                state_d = FL_SCAN;
                ptr_d   = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            state_q      <= FL_IDLE;
            ptr_q        <= '0;
            hit_valid_q  <= 1'b0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            hit_dirty_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hit_valid_q  <= do_lookup;
            hit_q        <= do_lookup & look_hit;
            hit_way_q    <= (do_lookup & look_hit) ? look_way : '0;
            hit_dirty_q  <= do_lookup & look_hit & dirty_q[look_way];
            flush_done_q <= flush_done_d;
        end
    end

    assign hit_valid  = hit_valid_q;
    assign hit        = hit_q;
    assign hit_way    = hit_way_q;
    assign hit_dirty  = hit_dirty_q;
    assign flush_done = flush_done_q;
    assign wb_valid   = (state_q == FL_WB);
    assign wb_tag     = wb_valid ? tag_q[ptr_q] : '0;
    assign wb_way     = wb_valid ? ptr_q : '0;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_WAYS; i++) occupancy = occupancy + CNTW'(valid_q[i]);
    end

endmodule

// File: tb/tb_vc_tag_store_lru.sv
// Directed checks of lookup, install/LRU, invalidate, flush writeback and reset.
module tb_vc_tag_store_lru;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_en, install_en, install_dirty, inv_en, flush_req, wb_ready;
    logic [19:0] lookup_tag, install_tag;
    logic [1:0]  inv_way;
    logic        hit_valid, hit, hit_dirty, victim_valid, victim_dirty;
    logic        flush_busy, flush_done, wb_valid;
    logic [1:0]  hit_way, victim_way, wb_way;
    logic [19:0] victim_tag, wb_tag;
    logic [2:0]  occupancy;

    int total = 0;
    int bad   = 0;

    vc_tag_store_lru #(.TAG_WIDTH(20), .NUM_WAYS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lookup_en(lookup_en), .lookup_tag(lookup_tag),
        .hit_valid(hit_valid), .hit(hit), .hit_way(hit_way), .hit_dirty(hit_dirty),
        .install_en(install_en), .install_tag(install_tag), .install_dirty(install_dirty),
        .victim_way(victim_way), .victim_valid(victim_valid),
        .victim_tag(victim_tag), .victim_dirty(victim_dirty),
        .inv_en(inv_en), .inv_way(inv_way),
        .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_way(wb_way),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic install(input logic [19:0] t, input logic d);
        install_en = 1'b1; install_tag = t; install_dirty = d;
        step();
        install_en = 1'b0;
    endtask

    task automatic lookup(input logic [19:0] t);
        lookup_en = 1'b1; lookup_tag = t;
        step();
        lookup_en = 1'b0;
    endtask

    task automatic wait_wb(input logic [1:0] way, input logic [19:0] t);
        int n = 0;
        while (!wb_valid && n < 20) begin
            step();
            n++;
        end
        chk("wb_seen", wb_valid, 1);
        chk("wb_way", wb_way, way);
        chk("wb_tag", wb_tag, t);
        repeat (3) begin
            step();
            chk("wb_hold_valid", wb_valid, 1);
            chk("wb_hold_way", wb_way, way);
            chk("wb_hold_tag", wb_tag, t);
            chk("busy_no_hit", hit_valid, 0);
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        lookup_en = 0; install_en = 0; install_dirty = 0; inv_en = 0;
        flush_req = 0; wb_ready = 0; lookup_tag = '0; install_tag = '0; inv_way = '0;
        #12;
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_victim", victim_way, 0);
        chk("rst_busy", flush_busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        rst_n = 1'b1;
        step();

        // fill: invalid ways are taken lowest first; ways 1 and 3 dirty
        for (int k = 0; k < 4; k++) begin
            chk("fill_victim", victim_way, k);
            chk("fill_victim_valid", victim_valid, 0);
            install(20'(k + 1), (k == 1 || k == 3));
        end
        chk("fill_occ", occupancy, 4);
        chk("full_victim", victim_way, 0);
        chk("full_victim_tag", victim_tag, 20'h00001);

        lookup(20'h00001);
        chk("lk1_valid", hit_valid, 1);
        chk("lk1_hit", hit, 1);
        chk("lk1_way", hit_way, 0);
        chk("lk1_dirty", hit_dirty, 0);
        chk("lru_victim", victim_way, 1);
        chk("lru_victim_tag", victim_tag, 20'h00002);
        chk("lru_victim_dirty", victim_dirty, 1);
        step();
        chk("lk_idle_valid", hit_valid, 0);

        install(20'h00005, 1'b1);
        lookup(20'h00005);
        chk("lk5_hit", hit, 1);
        chk("lk5_way", hit_way, 1);
        chk("lk5_dirty", hit_dirty, 1);
        lookup(20'h00099);
        chk("miss_valid", hit_valid, 1);
        chk("miss_hit", hit, 0);
        chk("miss_way", hit_way, 0);
        chk("v2_victim", victim_way, 2);
        chk("v2_victim_tag", victim_tag, 20'h00003);

        // invalidate and install aimed at the same way: only the invalidate happens
        inv_en = 1'b1; inv_way = 2'd2;
        install(20'h00077, 1'b0);
        inv_en = 1'b0;
        chk("same_occ", occupancy, 3);
        chk("same_victim", victim_way, 2);
        chk("same_victim_valid", victim_valid, 0);

        // different ways: both take effect
        inv_en = 1'b1; inv_way = 2'd0;
        install(20'h00033, 1'b0);
        inv_en = 1'b0;
        chk("diff_occ", occupancy, 3);
        chk("diff_victim", victim_way, 0);
        install(20'h00011, 1'b0);
        chk("refill_occ", occupancy, 4);
        chk("refill_victim", victim_way, 3);
        chk("refill_victim_tag", victim_tag, 20'h00004);

        // flush: way1 (0x5) and way3 (0x4) dirty, lookups ignored while busy
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        chk("fl_busy", flush_busy, 1);
        lookup_en = 1'b1; lookup_tag = 20'h00011;
        wait_wb(2'd1, 20'h00005);
        flush_req = 1'b1;
        wait_wb(2'd3, 20'h00004);
        flush_req = 1'b0;
        lookup_en = 1'b0;
        chk("fl_done", flush_done, 1);
        chk("fl_busy_end", flush_busy, 0);
        chk("fl_no_hit", hit_valid, 0);
        chk("fl_occ", occupancy, 0);
        step();
        chk("fl_done_pulse", flush_done, 0);
        chk("fl_stay_idle", flush_busy, 0);

        // reset asserted while a writeback is pending
        install(20'h0000A, 1'b1);
        install(20'h0000B, 1'b1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int n = 0; n < 10 && !wb_valid; n++) step();
        chk("rwb_seen", wb_valid, 1);
        chk("rwb_way", wb_way, 0);
        rst_n = 1'b0;
        #1;
        chk("rwb_valid", wb_valid, 0);
        chk("rwb_busy", flush_busy, 0);
        chk("rwb_occ", occupancy, 0);
        for (int i = 0; i < 4; i++) chk("rwb_age", dut.u_ages.age_q[i], i);
        rst_n = 1'b1;
        step();

        lookup(20'hFFFFF);
        chk("empty_valid", hit_valid, 1);
        chk("empty_hit", hit, 0);
        chk("empty_way", hit_way, 0);
        chk("empty_dirty", hit_dirty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
